// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: forwarding-mux selects and FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_sel.sv
// Select for one E-stage operand-forwarding 3:1 mux; the M stage wins over W, and x0 never forwards.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs_i,
    input  logic [ADDR_W-1:0] rd_m_i,
    input  logic [ADDR_W-1:0] rd_w_i,
    input  logic              reg_write_m_i,
    input  logic              reg_write_w_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        // NOTE: sel_o gets a default before any branch so no path leaves it unassigned (no latch).
        sel_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i == rs_i) && (rd_m_i != '0)) begin
            sel_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i == rs_i) && (rd_w_i != '0)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: operand forwarding, load-use stall, branch flush, memory-wait FSM.
// Optional: define HAZARD_PERF_EN to add StallCycles/FlushCount performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int TMO_W       = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Rs1D,
    input  logic [ADDR_W-1:0] Rs2D,
    input  logic [ADDR_W-1:0] Rs1E,
    input  logic [ADDR_W-1:0] Rs2E,
    input  logic [ADDR_W-1:0] RdE,
    input  logic [ADDR_W-1:0] RdM,
    input  logic [ADDR_W-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       StallCycles,
    output logic [31:0]       FlushCount
`endif
);

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [1:0]       fwd_a, fwd_b;
    logic             lw_stall, mem_stall;

    fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_a)
    );

    fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .sel_o         (fwd_b)
    );

    assign lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = ((state_q == ST_IDLE) && MemReqM && !MemReadyM) ||
                       ((state_q == ST_MEM_WAIT) && !MemReadyM);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next state; a dropped request also releases the wait so a lost access cannot hang the core.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (MemReqM && !MemReadyM) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
                if (MemReadyM || !MemReqM) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        mem_err_d = mem_err_q || ((state_q == ST_MEM_WAIT) && (tmo_cnt_d == TMO_MAX));
    end

    // Outputs; a memory wait freezes E, so load-use and branch effects are deferred until it clears.
    always_comb begin
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        StallF    = lw_stall;
        StallD    = lw_stall;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = PCSrcE;
        FlushE    = lw_stall || PCSrcE;
        FlushW    = 1'b0;
        if (reset) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end
    end

    assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (lw_stall || mem_stall) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (FlushE)                flush_count_q  <= flush_count_q + 32'd1;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then randomized traffic vs a behavioural model.
module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int TW  = 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef HAZARD_PERF_EN
    logic [31:0]   StallCycles, FlushCount;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a wait flag, cycles spent waiting, sticky error, perf counts.
    bit          m_wait;
    int          m_waited;
    bit          m_err;
    int unsigned m_stalls;
    int unsigned m_flushes;

    always #5 clk = ~clk;

    hazard_ctrl #(.ADDR_W(AW), .TMO_W(TW), .MEM_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .LoadE     (LoadE),
        .PCSrcE    (PCSrcE),
        .MemReqM   (MemReqM),
        .MemReadyM (MemReadyM),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushW    (FlushW),
        .MemErr    (MemErr)
`ifdef HAZARD_PERF_EN
        ,
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
        if (RegWriteM && RdM == rs && RdM != 0) return 2'b10;
        if (RegWriteW && RdW == rs && RdW != 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
    endtask

    // Called at a negedge with inputs already driven; checks, crosses one posedge, ends at next negedge.
    task automatic step();
        bit         lw, mem;
        logic [3:0] e_stall;
        logic [2:0] e_flush;
        #1;
        lw  = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        mem = MemReqM && !MemReadyM && (!m_wait || m_wait);
        mem = m_wait ? !MemReadyM : (MemReqM && !MemReadyM);
        if (reset) begin
            check("fwdA_rst", 32'(ForwardAE), 0);
            check("fwdB_rst", 32'(ForwardBE), 0);
            e_stall = 4'b0000;
            e_flush = 3'b111;
        end else begin
            check("fwdA", 32'(ForwardAE), 32'(exp_fwd(Rs1E)));
            check("fwdB", 32'(ForwardBE), 32'(exp_fwd(Rs2E)));
            if (mem) begin
                e_stall = 4'b1111;
                e_flush = 3'b001;
            end else begin
                e_stall = {lw, lw, 2'b00};
                e_flush = {PCSrcE, lw || PCSrcE, 1'b0};
            end
        end
        check("stall_FDEM", 32'({StallF, StallD, StallE, StallM}), 32'(e_stall));
        check("flush_DEW", 32'({FlushD, FlushE, FlushW}), 32'(e_flush));
        check("mem_err", 32'(MemErr), 32'(m_err));
`ifdef HAZARD_PERF_EN
        check("stall_cycles", StallCycles, m_stalls);
        check("flush_count", FlushCount, m_flushes);
`endif
        @(posedge clk);
        if (reset) begin
            m_wait    = 1'b0;
            m_waited  = 0;
            m_err     = 1'b0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (lw || mem) m_stalls++;
            if (e_flush[1]) m_flushes++;
            if (!m_wait) begin
                m_waited = 0;
                if (MemReqM && !MemReadyM) m_wait = 1'b1;
            end else begin
                if (m_waited < TMO) m_waited++;
                if (m_waited == TMO) m_err = 1'b1;
                if (MemReadyM || !MemReqM) m_wait = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        @(posedge clk);
        @(negedge clk);
        step();                      // reset held: flushes forced high
        reset = 1'b0;
        step();

        // Forwarding priority and x0 suppression.
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5;
        step();
        RegWriteM = 0;
        step();
        clear_inputs(); RegWriteM = 1; RdM = 0; Rs2E = 0;
        step();

        // Load-use hazard for one cycle.
        clear_inputs(); LoadE = 1; RdE = 7; Rs2D = 7;
        step();
        LoadE = 0;
        step();

        // Three-cycle memory wait with a taken branch held throughout.
        clear_inputs(); MemReqM = 1; PCSrcE = 1;
        repeat (3) step();
        MemReadyM = 1;
        step();
        clear_inputs();
        step();

        // Timeout: error rises and stays after ready, clears on reset.
        MemReqM = 1;
        repeat (7) step();
        MemReadyM = 1;
        step();
        clear_inputs();
        step();
        reset = 1;
        step();
        reset = 0;
        step();

        // Reset during a wait aborts it.
        MemReqM = 1;
        repeat (2) step();
        reset = 1;
        step();
        reset = 0; MemReqM = 0;
        step();

        // Randomized traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 800; i++) begin
            Rs1D      = AW'($urandom_range(0, 3));
            Rs2D      = AW'($urandom_range(0, 3));
            Rs1E      = AW'($urandom_range(0, 3));
            Rs2E      = AW'($urandom_range(0, 3));
            RdE       = AW'($urandom_range(0, 3));
            RdM       = AW'($urandom_range(0, 3));
            RdW       = AW'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            LoadE     = 1'($urandom_range(0, 1));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            MemReqM   = ($urandom_range(0, 9) != 0);
            MemReadyM = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
